// File: rtl/dual_issue_pkg.sv
// Shared types and constants for the fetch-to-decode dual-issue path.
package dual_issue_pkg;

  localparam logic [31:0] NOP_INST = 32'h0;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } dq_state_t;

  // Downstream credits above two are worth no more than two (dual issue).
  function automatic logic [1:0] sat_credit(input logic [2:0] credits);
    return (credits > 3'd2) ? 2'd2 : credits[1:0];
  endfunction

endpackage

// File: rtl/inst_fifo_2w2r.sv
// Instruction storage: two writes at waddr/waddr+1, two reads at raddr/raddr+1.
module inst_fifo_2w2r #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     we1_i,
  input  logic                     we2_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [XLEN-1:0]          wdata1_i,
  input  logic [XLEN-1:0]          wdata2_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [XLEN-1:0]          rdata1_o,
  output logic [XLEN-1:0]          rdata2_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   waddr_nxt;
  logic [PW-1:0]   raddr_nxt;

  // Pointer+1 wraps naturally at PW bits since DEPTH is a power of two.
  assign waddr_nxt = PW'(waddr_i + PW'(1));
  assign raddr_nxt = PW'(raddr_i + PW'(1));

  // Storage writes; contents are not reset, occupancy is tracked by the controller.
  always_ff @(posedge clk) begin
    if (we1_i) mem_q[waddr_i]   <= wdata1_i;
    if (we2_i) mem_q[waddr_nxt] <= wdata2_i;
  end

  assign rdata1_o = mem_q[raddr_i];
  assign rdata2_o = mem_q[raddr_nxt];

endmodule

// File: rtl/inst_dispatch_queue.sv
// Fetch-side instruction queue with in-order, credit-limited dual dispatch.
module inst_dispatch_queue
  import dual_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     fetch_valid,
  input  logic [1:0]               fetch_cnt,
  input  logic [XLEN-1:0]          fetch_inst1,
  input  logic [XLEN-1:0]          fetch_inst2,
  output logic                     fetch_ready,
  input  logic [2:0]               free_slots,
  output logic                     dec_valid1,
  output logic                     dec_valid2,
  output logic [XLEN-1:0]          dec_inst1,
  output logic [XLEN-1:0]          dec_inst2,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  dq_state_t       state_q, state_d;
  logic            run_en;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            cnt_ok, accept, we2;
  logic [1:0]      w, n, credits;
  logic [XLEN-1:0] rd1, rd2;
  logic            dec_valid1_q, dec_valid2_q;
  logic [XLEN-1:0] dec_inst1_q, dec_inst2_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // FSM next state: flush always lands in FLUSH, which otherwise lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:   if (flush) state_d = FLUSH;
      FLUSH: state_d = flush ? FLUSH : RUN;
    endcase
  end

  // FSM output: accept and dispatch are only enabled in RUN
  always_comb begin
    run_en = 1'b0;
    case (state_q)
      RUN:   run_en = 1'b1;
      FLUSH: run_en = 1'b0;
    endcase
  end

  // Ready depends on registered state only and ignores same-cycle dispatch
  assign fetch_ready = run_en & ((CW'(DEPTH) - count_q) >= CW'(2));
  assign cnt_ok      = (fetch_cnt == 2'd1) | (fetch_cnt == 2'd2);
  assign accept      = fetch_valid & fetch_ready & cnt_ok & ~flush;
  assign we2         = accept & (fetch_cnt == 2'd2);
  assign w           = accept ? fetch_cnt : 2'd0;
  assign credits     = sat_credit(free_slots);

  // Dispatch count = min(registered count, credits, 2); nothing leaves during a flush
  always_comb begin
    n = credits;
    if (count_q < CW'(credits)) n = count_q[1:0];
    if (!run_en || flush)       n = 2'd0;
  end

  // Next pointers and occupancy
  always_comb begin
    head_d  = PW'(head_q + PW'(n));
    tail_d  = PW'(tail_q + PW'(w));
    count_d = CW'(count_q + CW'(w) - CW'(n));
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  inst_fifo_2w2r #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk      (clk),
    .we1_i    (accept),
    .we2_i    (we2),
    .waddr_i  (tail_q),
    .wdata1_i (fetch_inst1),
    .wdata2_i (fetch_inst2),
    .raddr_i  (head_q),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  // Decoder-facing output pair: one-cycle pulses, NOP in empty slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid1_q <= 1'b0;
      dec_valid2_q <= 1'b0;
      dec_inst1_q  <= XLEN'(NOP_INST);
      dec_inst2_q  <= XLEN'(NOP_INST);
    end else begin
      dec_valid1_q <= (n >= 2'd1);
      dec_valid2_q <= (n == 2'd2);
      dec_inst1_q  <= (n >= 2'd1) ? rd1 : XLEN'(NOP_INST);
      dec_inst2_q  <= (n == 2'd2) ? rd2 : XLEN'(NOP_INST);
    end
  end

  assign dec_valid1 = dec_valid1_q;
  assign dec_valid2 = dec_valid2_q;
  assign dec_inst1  = dec_inst1_q;
  assign dec_inst2  = dec_inst2_q;
  assign q_count    = count_q;

  // Occupancy must stay within [0, DEPTH]
  assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));
  assert property (@(posedge clk) disable iff (!rst_n)
                   (32'(count_q) + 32'(w)) >= 32'(n));
  assert property (@(posedge clk) disable iff (!rst_n)
                   (32'(count_q) + 32'(w) - 32'(n)) <= 32'(DEPTH));

endmodule

// File: tb/tb_inst_dispatch_queue.sv
// Self-checking bench for inst_dispatch_queue against a queue-based reference model.
module tb_inst_dispatch_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk, rst_n, flush, fetch_valid, fetch_ready;
  logic [1:0]      fetch_cnt;
  logic [XLEN-1:0] fetch_inst1, fetch_inst2, dec_inst1, dec_inst2;
  logic [2:0]      free_slots;
  logic            dec_valid1, dec_valid2;
  logic [CW-1:0]   q_count;

  inst_dispatch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_cnt   (fetch_cnt),
    .fetch_inst1 (fetch_inst1),
    .fetch_inst2 (fetch_inst2),
    .fetch_ready (fetch_ready),
    .free_slots  (free_slots),
    .dec_valid1  (dec_valid1),
    .dec_valid2  (dec_valid2),
    .dec_inst1   (dec_inst1),
    .dec_inst2   (dec_inst2),
    .q_count     (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: program-order queue plus flush-cycle flag
  logic [31:0] mq[$];
  bit          m_inflush;
  bit          exp_v1, exp_v2, exp_ready;
  logic [31:0] exp_i1, exp_i2;
  int          exp_cnt;

  task automatic model_reset();
    mq.delete();
    m_inflush = 0;
    exp_v1 = 0; exp_v2 = 0; exp_i1 = 0; exp_i2 = 0;
    exp_cnt = 0; exp_ready = 1;
  endtask

  // One clock of stimulus; model predicts the state right after the edge
  task automatic drive(input bit fv, input int fc, input logic [31:0] a,
                       input logic [31:0] b, input int fs, input bit fl,
                       output bit acc);
    int  n;
    bit  rdy;
    rdy = !m_inflush && (DEPTH - mq.size() >= 2);
    acc = fv && rdy && !fl && (fc == 1 || fc == 2);
    fetch_valid = fv; fetch_cnt = 2'(fc); fetch_inst1 = a; fetch_inst2 = b;
    free_slots = 3'(fs); flush = fl;
    @(posedge clk); #1;
    fetch_valid = 0; flush = 0;
    exp_v1 = 0; exp_v2 = 0; exp_i1 = 0; exp_i2 = 0;
    if (fl) begin
      mq.delete();
      m_inflush = 1;
    end else begin
      n = 0;
      if (!m_inflush) begin
        n = (fs > 2) ? 2 : fs;
        if (mq.size() < n) n = mq.size();
      end
      if (n >= 1) begin exp_v1 = 1; exp_i1 = mq.pop_front(); end
      if (n == 2) begin exp_v2 = 1; exp_i2 = mq.pop_front(); end
      if (acc) begin
        mq.push_back(a);
        if (fc == 2) mq.push_back(b);
      end
      m_inflush = 0;
    end
    exp_cnt   = mq.size();
    exp_ready = !m_inflush && (DEPTH - mq.size() >= 2);
  endtask

  task automatic test_reset();
    bit acc;
    n_cmp++; if (q_count !== '0 || dec_valid1 !== 0 || dec_valid2 !== 0 || dec_inst1 !== 0 || dec_inst2 !== 0) begin
      n_err++; $display("FAIL reset_init: q_count=%0d v1=%0b v2=%0b i1=%h i2=%h, want all 0", q_count, dec_valid1, dec_valid2, dec_inst1, dec_inst2);
    end
    n_cmp++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", fetch_ready); end
    for (int k = 0; k < 3; k++) drive(1, 2, 32'hA000_0000 + 32'(2*k), 32'hA000_0001 + 32'(2*k), 0, 0, acc);
    drive(0, 0, 0, 0, 1, 0, acc);
    n_cmp++; if (q_count !== CW'(5) || dec_valid1 !== 1'b1 || dec_inst1 !== 32'hA000_0000) begin
      n_err++; $display("FAIL reset_prefill: q_count=%0d v1=%b i1=%h, want 5 1 a0000000", q_count, dec_valid1, dec_inst1);
    end
    rst_n = 0; #2;
    n_cmp++; if (q_count !== '0 || dec_valid1 !== 0 || dec_valid2 !== 0 || dec_inst1 !== 0 || dec_inst2 !== 0) begin
      n_err++; $display("FAIL reset_async: q_count=%0d v1=%b v2=%b i1=%h i2=%h, want all 0", q_count, dec_valid1, dec_valid2, dec_inst1, dec_inst2);
    end
    @(negedge clk); rst_n = 1; #1;
    model_reset();
    n_cmp++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", fetch_ready); end
  endtask

  task automatic test_pair_dispatch();
    bit acc;
    drive(1, 2, 32'h0050_0093, 32'h00A0_0113, 2, 0, acc);
    n_cmp++; if (q_count !== CW'(2) || dec_valid1 !== 0) begin
      n_err++; $display("FAIL pair_written: q_count=%0d v1=%b, want 2 0", q_count, dec_valid1);
    end
    drive(0, 0, 0, 0, 2, 0, acc);
    n_cmp++; if (dec_valid1 !== 1 || dec_valid2 !== 1 || dec_inst1 !== 32'h0050_0093 || dec_inst2 !== 32'h00A0_0113) begin
      n_err++; $display("FAIL pair_out: v1=%b v2=%b i1=%h i2=%h, want 1 1 00500093 00a00113", dec_valid1, dec_valid2, dec_inst1, dec_inst2);
    end
    n_cmp++; if (q_count !== '0) begin n_err++; $display("FAIL pair_count: got %0d want 0", q_count); end
    drive(0, 0, 0, 0, 2, 0, acc);
    n_cmp++; if (dec_valid1 !== 0 || dec_valid2 !== 0 || dec_inst1 !== 0) begin
      n_err++; $display("FAIL pair_pulse: v1=%b v2=%b i1=%h, want 0 0 0", dec_valid1, dec_valid2, dec_inst1);
    end
  endtask

  task automatic test_single_credit();
    bit acc;
    logic [31:0] ord [3];
    ord[0] = 32'h0000_1111; ord[1] = 32'h0000_2222; ord[2] = 32'h0000_3333;
    drive(1, 1, 32'h0020_8233, 32'hDEAD_BEEF, 2, 0, acc);
    drive(0, 0, 0, 0, 2, 0, acc);
    n_cmp++; if (dec_valid1 !== 1 || dec_inst1 !== 32'h0020_8233 || dec_valid2 !== 0 || dec_inst2 !== 0) begin
      n_err++; $display("FAIL single: v1=%b i1=%h v2=%b i2=%h, want 1 00208233 0 0", dec_valid1, dec_inst1, dec_valid2, dec_inst2);
    end
    drive(1, 2, ord[0], ord[1], 0, 0, acc);
    drive(1, 1, ord[2], 0, 0, 0, acc);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, 0, acc);
      n_cmp++; if (dec_valid1 !== 1 || dec_inst1 !== ord[k] || dec_valid2 !== 0 || q_count !== CW'(2 - k)) begin
        n_err++; $display("FAIL credit1_%0d: v1=%b i1=%h v2=%b cnt=%0d, want 1 %h 0 %0d", k, dec_valid1, dec_inst1, dec_valid2, q_count, ord[k], 2 - k);
      end
    end
  endtask

  task automatic test_full();
    bit acc;
    // 7 entries: not enough room for a pair
    for (int k = 0; k < 3; k++) drive(1, 2, 32'h2000_0000 + 32'(2*k), 32'h2000_0001 + 32'(2*k), 0, 0, acc);
    drive(1, 1, 32'h2000_0006, 0, 0, 0, acc);
    n_cmp++; if (q_count !== CW'(7) || fetch_ready !== 0) begin
      n_err++; $display("FAIL full7: cnt=%0d ready=%b, want 7 0", q_count, fetch_ready);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 2, 0, acc);
      n_cmp++; if (dec_valid1 !== exp_v1 || dec_inst1 !== exp_i1 || dec_valid2 !== exp_v2 || dec_inst2 !== exp_i2 || q_count !== CW'(exp_cnt)) begin
        n_err++; $display("FAIL drain7_%0d: v1=%b i1=%h v2=%b i2=%h cnt=%0d, want %b %h %b %h %0d", k, dec_valid1, dec_inst1, dec_valid2, dec_inst2, q_count, exp_v1, exp_i1, exp_v2, exp_i2, exp_cnt);
      end
    end
    // 8 entries: completely full, extra push dropped
    for (int k = 0; k < 4; k++) drive(1, 2, 32'h3000_0000 + 32'(2*k), 32'h3000_0001 + 32'(2*k), 0, 0, acc);
    n_cmp++; if (q_count !== CW'(8) || fetch_ready !== 0) begin
      n_err++; $display("FAIL full8: cnt=%0d ready=%b, want 8 0", q_count, fetch_ready);
    end
    drive(1, 2, 32'hBAD0_0001, 32'hBAD0_0002, 0, 0, acc);
    n_cmp++; if (q_count !== CW'(8) || acc) begin
      n_err++; $display("FAIL full_drop: cnt=%0d, want 8", q_count);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 2, 0, acc);
      n_cmp++; if (dec_valid1 !== 1 || dec_valid2 !== 1 || dec_inst1 !== 32'h3000_0000 + 32'(2*k) || dec_inst2 !== 32'h3000_0001 + 32'(2*k)) begin
        n_err++; $display("FAIL drain8_%0d: v1=%b v2=%b i1=%h i2=%h, want 1 1 %h %h", k, dec_valid1, dec_valid2, dec_inst1, dec_inst2, 32'h3000_0000 + 32'(2*k), 32'h3000_0001 + 32'(2*k));
      end
    end
    n_cmp++; if (q_count !== '0 || fetch_ready !== 1) begin
      n_err++; $display("FAIL full_empty: cnt=%0d ready=%b, want 0 1", q_count, fetch_ready);
    end
  endtask

  task automatic test_wrap_random();
    bit acc;
    int pushes, fc;
    logic [31:0] a, b;
    logic [31:0] sent[$];
    logic [31:0] got[$];
    pushes = 0;
    for (int cyc = 0; cyc < 400 && (pushes < 20 || mq.size() > 0); cyc++) begin
      fc = 1 + int'($urandom_range(0, 1));
      a  = $urandom | 32'h1;
      b  = $urandom | 32'h1;
      if (pushes < 20)
        drive($urandom_range(0, 3) != 0, fc, a, b, int'($urandom_range(0, 3)), 0, acc);
      else
        drive(0, 0, 0, 0, int'($urandom_range(0, 7)), 0, acc);
      if (acc) begin
        pushes++;
        sent.push_back(a);
        if (fc == 2) sent.push_back(b);
      end
      if (dec_valid1 === 1'b1) got.push_back(dec_inst1);
      if (dec_valid2 === 1'b1) got.push_back(dec_inst2);
      n_cmp++; if (dec_valid1 !== exp_v1 || dec_inst1 !== exp_i1 || dec_valid2 !== exp_v2 || dec_inst2 !== exp_i2 || q_count !== CW'(exp_cnt) || fetch_ready !== exp_ready) begin
        n_err++; $display("FAIL rand_cyc%0d: v1=%b i1=%h v2=%b i2=%h cnt=%0d rdy=%b, want %b %h %b %h %0d %b", cyc, dec_valid1, dec_inst1, dec_valid2, dec_inst2, q_count, fetch_ready, exp_v1, exp_i1, exp_v2, exp_i2, exp_cnt, exp_ready);
      end
    end
    n_cmp++; if (pushes < 20 || got.size() != sent.size()) begin
      n_err++; $display("FAIL rand_total: pushes=%0d got=%0d, want >=20 and %0d", pushes, got.size(), sent.size());
    end
    for (int k = 0; k < sent.size() && k < got.size(); k++) begin
      n_cmp++; if (got[k] !== sent[k]) begin
        n_err++; $display("FAIL rand_order%0d: got %h want %h", k, got[k], sent[k]);
      end
    end
  endtask

  task automatic test_flush();
    bit acc;
    for (int k = 0; k < 2; k++) drive(1, 2, 32'h5000_0000 + 32'(2*k), 32'h5000_0001 + 32'(2*k), 0, 0, acc);
    drive(1, 1, 32'h5000_0004, 0, 0, 0, acc);
    n_cmp++; if (q_count !== CW'(5)) begin n_err++; $display("FAIL flush_pre: cnt=%0d want 5", q_count); end
    drive(1, 2, 32'h5000_0005, 32'h5000_0006, 2, 1, acc);
    n_cmp++; if (q_count !== '0 || dec_valid1 !== 0 || dec_valid2 !== 0 || dec_inst1 !== 0 || dec_inst2 !== 0 || fetch_ready !== 0) begin
      n_err++; $display("FAIL flush_edge: cnt=%0d v1=%b v2=%b i1=%h i2=%h rdy=%b, want 0 0 0 0 0 0", q_count, dec_valid1, dec_valid2, dec_inst1, dec_inst2, fetch_ready);
    end
    drive(1, 2, 32'hBAD0_0003, 32'hBAD0_0004, 2, 0, acc);
    n_cmp++; if (q_count !== '0 || dec_valid1 !== 0 || fetch_ready !== 1) begin
      n_err++; $display("FAIL flush_hold: cnt=%0d v1=%b rdy=%b, want 0 0 1", q_count, dec_valid1, fetch_ready);
    end
    drive(1, 2, 32'h6000_0000, 32'h6000_0001, 2, 0, acc);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 2, 0, acc);
      n_cmp++; if (dec_valid1 !== exp_v1 || dec_inst1 !== exp_i1 || dec_valid2 !== exp_v2 || dec_inst2 !== exp_i2 || q_count !== CW'(exp_cnt) || (dec_valid1 === 1'b1 && dec_inst1[31:28] != 4'h6)) begin
        n_err++; $display("FAIL post_flush_%0d: v1=%b i1=%h v2=%b i2=%h cnt=%0d, want %b %h %b %h %0d", k, dec_valid1, dec_inst1, dec_valid2, dec_inst2, q_count, exp_v1, exp_i1, exp_v2, exp_i2, exp_cnt);
      end
    end
  endtask

  initial begin
    rst_n = 0; flush = 0; fetch_valid = 0; fetch_cnt = 0;
    fetch_inst1 = 0; fetch_inst2 = 0; free_slots = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    #1;
    test_reset();
    test_pair_dispatch();
    test_single_credit();
    test_full();
    test_wrap_random();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
